// File: rtl/load_store_unit_pkg.sv
// Shared ISA definitions for the memory stage.
// - ALU operation codes (8-bit shared encoding)
// - access_size_e: width of a memory access (BYTE, HALF, WORD)
// - classification helpers: is_load, is_store, access_size, is_misaligned
// - bus helpers: byte_enables, store_wdata (lane replication)
package load_store_unit_pkg;

  typedef enum logic [1:0] {BYTE, HALF, WORD} access_size_e;

  localparam logic [7:0] OP_ADD  = 8'h00;
  localparam logic [7:0] OP_SUB  = 8'h01;
  localparam logic [7:0] OP_AND  = 8'h02;
  localparam logic [7:0] OP_OR   = 8'h03;
  localparam logic [7:0] OP_XOR  = 8'h04;
  localparam logic [7:0] OP_SLL  = 8'h05;
  localparam logic [7:0] OP_SRL  = 8'h06;
  localparam logic [7:0] OP_SRA  = 8'h07;
  localparam logic [7:0] OP_SLT  = 8'h08;
  localparam logic [7:0] OP_SLTU = 8'h09;
  localparam logic [7:0] OP_LB   = 8'h10;
  localparam logic [7:0] OP_LH   = 8'h11;
  localparam logic [7:0] OP_LW   = 8'h12;
  localparam logic [7:0] OP_LBU  = 8'h13;
  localparam logic [7:0] OP_LHU  = 8'h14;
  localparam logic [7:0] OP_SB   = 8'h18;
  localparam logic [7:0] OP_SH   = 8'h19;
  localparam logic [7:0] OP_SW   = 8'h1A;

  function automatic logic is_load(input logic [7:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  // Non-memory ops report WORD; callers only use the size for memory ops.
  function automatic access_size_e access_size(input logic [7:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return BYTE;
      OP_LH, OP_LHU, OP_SH: return HALF;
      default:              return WORD;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [7:0] op, input logic [1:0] addr_lo);
    case (access_size(op))
      HALF:    return addr_lo[0];
      WORD:    return addr_lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] byte_enables(input logic [7:0] op, input logic [1:0] addr_lo);
    case (access_size(op))
      BYTE:    return 4'b0001 << addr_lo;
      HALF:    return addr_lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Narrow stores replicate the operand into every lane so the memory can
  // pick it up with the byte enables alone.
  function automatic logic [31:0] store_wdata(input logic [7:0] op, input logic [31:0] data);
    case (access_size(op))
      BYTE:    return {4{data[7:0]}};
      HALF:    return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_data_extractor.sv
// Combinational load data extraction.
// Ports:
//   op      - load operation code (LB/LH/LW/LBU/LHU)
//   addr_lo - low two address bits selecting the byte/half lane
//   rdata   - raw 32-bit word from memory
//   data    - extracted, sign- or zero-extended result
module load_data_extractor
  import load_store_unit_pkg::*;
(
  input  logic [7:0]  op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    byte_lane = rdata[{addr_lo, 3'b000} +: 8];
    half_lane = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      OP_LB:   data = {{24{byte_lane[7]}}, byte_lane};
      OP_LBU:  data = {24'h0, byte_lane};
      OP_LH:   data = {{16{half_lane[15]}}, half_lane};
      OP_LHU:  data = {16'h0, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit.
// Accepts one execute-stage result at a time. Non-memory ops pass alu_result
// straight to writeback; loads/stores run a request/grant/response bus
// transaction and stall upstream (in_ready low) until it completes.
// Ports:
//   clk, rst_n                       - clock, async active-low reset
//   in_valid/in_ready                - upstream handshake
//   alu_operation/alu_result/store_data - execute-stage outputs
//   mem_req/we/be/addr/wdata         - memory request channel
//   mem_gnt/mem_rvalid/mem_rdata     - memory grant and read response
//   out_valid/out_data               - one-cycle writeback pulse and value
//   misaligned_fault/bus_fault       - fault qualifiers on out_valid
//   dbg_state                        - current FSM state for observation
//
// Handshake: an op transfers on a cycle where in_valid && in_ready; upstream
// holds its inputs while in_ready is low. mem_req and its payload stay stable
// until the cycle mem_gnt is seen high; read data transfers on mem_rvalid.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  alu_operation,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        misaligned_fault,
  output logic        bus_fault,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_e;

  state_e      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [7:0]  op_q, op_d;
  logic [1:0]  addr_lo_q, addr_lo_d;

  logic        mem_req_d, mem_we_d;
  logic [3:0]  mem_be_d;
  logic [31:0] mem_addr_d, mem_wdata_d;
  logic        out_valid_d, mis_d, bus_d;
  logic [31:0] out_data_d;

  logic        accept, mem_op, misaligned, timeout_hit;
  logic [31:0] load_value;

  assign accept     = in_valid && in_ready;
  assign mem_op     = is_load(alu_operation) || is_store(alu_operation);
  assign misaligned = is_misaligned(alu_operation, alu_result[1:0]);
  // Fires on the cycle whose increment would reach the limit, so the
  // registered fault appears exactly TIMEOUT_CYCLES cycles after entry.
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((cnt_q + 32'd1) == TIMEOUT_CYCLES);

  load_data_extractor u_extract (
    .op      (op_q),
    .addr_lo (addr_lo_q),
    .rdata   (mem_rdata),
    .data    (load_value)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a grant beats a simultaneous timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && mem_op && !misaligned) state_d = REQ;
      REQ:     if (mem_gnt)     state_d = is_load(op_q) ? WAIT_R : IDLE;
               else if (timeout_hit) state_d = IDLE;
      WAIT_R:  if (mem_rvalid || timeout_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic: next values of the registered bus/writeback outputs.
  always_comb begin
    in_ready    = (state_q == IDLE);
    dbg_state   = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    addr_lo_d   = addr_lo_q;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_be_d    = mem_be;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    out_valid_d = 1'b0;
    mis_d       = 1'b0;
    bus_d       = 1'b0;
    out_data_d  = out_data;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!mem_op) begin
            out_valid_d = 1'b1;
            out_data_d  = alu_result;
          end else if (misaligned) begin
            out_valid_d = 1'b1;
            mis_d       = 1'b1;
            out_data_d  = 32'h0;
          end else begin
            cnt_d       = 32'h0;
            op_d        = alu_operation;
            addr_lo_d   = alu_result[1:0];
            mem_req_d   = 1'b1;
            mem_we_d    = is_store(alu_operation);
            mem_be_d    = byte_enables(alu_operation, alu_result[1:0]);
            mem_addr_d  = {alu_result[31:2], 2'b00};
            mem_wdata_d = is_store(alu_operation) ? store_wdata(alu_operation, store_data) : 32'h0;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 32'd1;
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          cnt_d     = 32'h0;
          if (!is_load(op_q)) out_valid_d = 1'b1;
        end else if (timeout_hit) begin
          mem_req_d   = 1'b0;
          out_valid_d = 1'b1;
          bus_d       = 1'b1;
          out_data_d  = 32'h0;
        end
      end
      WAIT_R: begin
        cnt_d = cnt_q + 32'd1;
        if (mem_rvalid) begin
          out_valid_d = 1'b1;
          out_data_d  = load_value;
        end else if (timeout_hit) begin
          out_valid_d = 1'b1;
          bus_d       = 1'b1;
          out_data_d  = 32'h0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q            <= 32'h0;
      op_q             <= OP_ADD;
      addr_lo_q        <= 2'b00;
      mem_req          <= 1'b0;
      mem_we           <= 1'b0;
      mem_be           <= 4'h0;
      mem_addr         <= 32'h0;
      mem_wdata        <= 32'h0;
      out_valid        <= 1'b0;
      out_data         <= 32'h0;
      misaligned_fault <= 1'b0;
      bus_fault        <= 1'b0;
    end else begin
      cnt_q            <= cnt_d;
      op_q             <= op_d;
      addr_lo_q        <= addr_lo_d;
      mem_req          <= mem_req_d;
      mem_we           <= mem_we_d;
      mem_be           <= mem_be_d;
      mem_addr         <= mem_addr_d;
      mem_wdata        <= mem_wdata_d;
      out_valid        <= out_valid_d;
      out_data         <= out_data_d;
      misaligned_fault <= mis_d;
      bus_fault        <= bus_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;
  import load_store_unit_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  alu_operation = 8'h0;
  logic [31:0] alu_result = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        out_valid;
  logic [31:0] out_data;
  logic        misaligned_fault, bus_fault;
  logic [1:0]  dbg_state;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .alu_operation(alu_operation), .alu_result(alu_result), .store_data(store_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_data(out_data),
    .misaligned_fault(misaligned_fault), .bus_fault(bus_fault), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Compares the current writeback against the oldest expected value.
  task automatic check_wb(input string tag);
    logic [31:0] exp;
    exp = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hx;
    check({tag, "_valid"}, {31'h0, out_valid}, 32'd1);
    check({tag, "_data"}, out_data, exp);
  endtask

  // ---------------- driver tasks ----------------
  // Outputs are sampled 1ns after the rising edge; inputs change there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one op for one accepting edge; on return we are in cycle N+1.
  task automatic issue(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] sd);
    alu_operation = op;
    alu_result    = addr;
    store_data    = sd;
    in_valid      = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Aligned load: gnt on first request cycle, rvalid the cycle after.
  task automatic do_load(input string tag, input logic [7:0] op, input logic [31:0] addr,
                         input logic [3:0] be, input logic [31:0] rdata, input logic [31:0] exp);
    exp_q.push_back(exp);
    issue(op, addr, 32'hFFFF_FFFF);
    check({tag, "_req"}, {31'h0, mem_req}, 32'd1);
    check({tag, "_we"}, {31'h0, mem_we}, 32'd0);
    check({tag, "_be"}, {28'h0, mem_be}, {28'h0, be});
    check({tag, "_wdata"}, mem_wdata, 32'h0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    check({tag, "_noval_wait"}, {31'h0, out_valid}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    step();
    mem_rvalid = 1'b0;
    check_wb(tag);
    step();
  endtask

  // Aligned store: gnt on first request cycle.
  task automatic do_store(input string tag, input logic [7:0] op, input logic [31:0] addr,
                          input logic [31:0] sd, input logic [3:0] be, input logic [31:0] wdata);
    issue(op, addr, sd);
    check({tag, "_req"}, {31'h0, mem_req}, 32'd1);
    check({tag, "_we"}, {31'h0, mem_we}, 32'd1);
    check({tag, "_be"}, {28'h0, mem_be}, {28'h0, be});
    check({tag, "_addr"}, mem_addr, {addr[31:2], 2'b00});
    check({tag, "_wdata"}, mem_wdata, wdata);
    check({tag, "_ready"}, {31'h0, in_ready}, 32'd0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    check({tag, "_req_drop"}, {31'h0, mem_req}, 32'd0);
    check({tag, "_valid"}, {31'h0, out_valid}, 32'd1);
    step();
    check({tag, "_pulse"}, {31'h0, out_valid}, 32'd0);
    check({tag, "_ready_back"}, {31'h0, in_ready}, 32'd1);
  endtask

  // ---------------- directed test ----------------
  initial begin
    int k;
    int seen;
    repeat (3) step();
    check("rst_req", {31'h0, mem_req}, 32'd0);
    check("rst_out_valid", {31'h0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_be", {28'h0, mem_be}, 32'h0);
    check("rst_ready", {31'h0, in_ready}, 32'd1);
    rst_n = 1'b1;
    step();

    // Pass-through: out_valid at N+1, no bus activity.
    exp_q.push_back(32'h0000_1234);
    issue(OP_ADD, 32'h0000_1234, 32'h0);
    check_wb("add");
    check("add_noreq", {31'h0, mem_req}, 32'd0);
    step();
    check("add_pulse", {31'h0, out_valid}, 32'd0);

    exp_q.push_back(32'hCAFE_0001);
    issue(OP_XOR, 32'hCAFE_0001, 32'h0);
    check_wb("xor");

    // Stores
    do_store("sb", OP_SB, 32'h0000_1003, 32'h0000_00AB, 4'b1000, 32'hABAB_ABAB);
    do_store("sh", OP_SH, 32'h0000_2002, 32'h1234_5678, 4'b1100, 32'h5678_5678);
    do_store("sw", OP_SW, 32'h0000_3000, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

    // Loads against rdata 0x1280_FF34
    do_load("lb",  OP_LB,  32'h0000_2002, 4'b0100, 32'h1280_FF34, 32'hFFFF_FF80);
    do_load("lbu", OP_LBU, 32'h0000_2002, 4'b0100, 32'h1280_FF34, 32'h0000_0080);
    do_load("lb1", OP_LB,  32'h0000_2001, 4'b0010, 32'h1280_FF34, 32'hFFFF_FFFF);
    do_load("lh",  OP_LH,  32'h0000_2002, 4'b1100, 32'h1280_FF34, 32'h0000_1280);
    do_load("lh0", OP_LH,  32'h0000_2000, 4'b0011, 32'h1280_FF34, 32'hFFFF_FF34);
    do_load("lhu", OP_LHU, 32'h0000_2000, 4'b0011, 32'h1280_FF34, 32'h0000_FF34);
    do_load("lw",  OP_LW,  32'h0000_2000, 4'b1111, 32'h1280_FF34, 32'h1280_FF34);

    // Misaligned: fault at N+1, no request, out_data forced to 0.
    issue(OP_LW, 32'h0000_2002, 32'h0);
    check("mis_lw_valid", {31'h0, out_valid}, 32'd1);
    check("mis_lw_fault", {31'h0, misaligned_fault}, 32'd1);
    check("mis_lw_data", out_data, 32'h0);
    check("mis_lw_noreq", {31'h0, mem_req}, 32'd0);
    step();
    check("mis_lw_pulse", {31'h0, misaligned_fault}, 32'd0);
    check("mis_lw_noreq2", {31'h0, mem_req}, 32'd0);
    exp_q.push_back(32'h0000_0055);
    issue(OP_ADD, 32'h0000_0055, 32'h0);
    check_wb("add2");
    issue(OP_SH, 32'h0000_2001, 32'h1111_2222);
    check("mis_sh_fault", {31'h0, misaligned_fault}, 32'd1);
    check("mis_sh_data", out_data, 32'h0);
    check("mis_sh_noreq", {31'h0, mem_req}, 32'd0);
    step();

    // Stray rvalid while still in REQ must be ignored.
    issue(OP_LW, 32'h0000_5000, 32'h0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h0000_0BAD;
    step();
    mem_rvalid = 1'b0;
    check("stray_noval", {31'h0, out_valid}, 32'd0);
    check("stray_req_held", {31'h0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    step();
    mem_gnt    = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h600D_F00D;
    exp_q.push_back(32'h600D_F00D);
    step();
    mem_rvalid = 1'b0;
    check_wb("stray_load");
    step();

    // Timeout: granted load, rvalid never comes; fault 4 cycles after WAIT_R entry.
    issue(OP_LW, 32'h0000_6000, 32'h0);
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    k = 0;
    seen = 0;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (out_valid) begin
        k = i;
        seen = 1;
        break;
      end
    end
    check("to_seen", seen, 1);
    check("to_latency", k, 4);
    check("to_bus_fault", {31'h0, bus_fault}, 32'd1);
    check("to_data", out_data, 32'h0);
    check("to_ready", {31'h0, in_ready}, 32'd1);
    step();
    check("to_pulse", {31'h0, bus_fault}, 32'd0);

    // Store with gnt withheld; reset asserted in its 2nd request cycle.
    issue(OP_SW, 32'h0000_7004, 32'h0BAD_CAFE);
    check("hold1_req", {31'h0, mem_req}, 32'd1);
    check("hold1_addr", mem_addr, 32'h0000_7004);
    check("hold1_wdata", mem_wdata, 32'h0BAD_CAFE);
    check("hold1_ready", {31'h0, in_ready}, 32'd0);
    step();
    check("hold2_req", {31'h0, mem_req}, 32'd1);
    check("hold2_addr", mem_addr, 32'h0000_7004);
    check("hold2_wdata", mem_wdata, 32'h0BAD_CAFE);
    check("hold2_ready", {31'h0, in_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    check("midrst_req", {31'h0, mem_req}, 32'd0);
    check("midrst_ready", {31'h0, in_ready}, 32'd1);
    step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (out_valid) seen++;
    end
    check("midrst_no_valid", seen, 0);
    check("midrst_req_low", {31'h0, mem_req}, 32'd0);

    // Unit is usable again after the mid-transaction reset.
    do_store("post_sb", OP_SB, 32'h0000_8000, 32'h0000_0042, 4'b0001, 32'h4242_4242);

    check("exp_q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  // Global watchdog so the bench never hangs.
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage consumer of the execute-stage outputs: the ALU operation code, the ALU result (effective address) and the store operand.
- For load/store operations it drives a request/grant/response data-memory bus with byte enables and lane-replicated write data.
- For loads it extracts and sign- or zero-extends the returned data; all other operations pass straight through to writeback.
- Stalls the pipeline while a memory transaction is outstanding.

Parameters:
TIMEOUT_CYCLES, 0, cycles to wait for mem_gnt or mem_rvalid before reporting bus_fault; 0 disables the timeout.

Ports:
clk  input  1  core clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  execute-stage result valid
in_ready  output  1  unit can accept; high only in IDLE
alu_operation  input  8  ALU operation code (shared ISA encoding)
alu_result  input  32  ALU result; effective address for load/store
store_data  input  32  rs2 value for stores
mem_req  output  1  memory request
mem_we  output  1  1 = write
mem_be  output  4  byte enables
mem_addr  output  32  word-aligned address (alu_result with [1:0] forced to 0)
mem_wdata  output  32  lane-replicated write data
mem_gnt  input  1  request accepted
mem_rvalid  input  1  read data valid
mem_rdata  input  32  read data
out_valid  output  1  one-cycle writeback pulse
out_data  output  32  loaded value or passed-through alu_result
misaligned_fault  output  1  qualifies out_valid
bus_fault  output  1  qualifies out_valid

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Reset puts the FSM in IDLE and zeroes mem_req, mem_we, mem_be, mem_addr, mem_wdata, out_valid, out_data, both fault flags and the timeout counter.
- Handshake: an operation is accepted when in_valid && in_ready. Upstream holds its inputs stable while in_ready is low.
- FSM states: IDLE, REQ, WAIT_R.
- IDLE, non-memory op accepted: next cycle out_valid=1 and out_data=alu_result. No bus activity.
- IDLE, memory op accepted, misaligned: next cycle out_valid=1, misaligned_fault=1, out_data=0. No request is issued.
  - Misaligned means LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
- IDLE, memory op accepted, aligned: register the request and go to REQ. mem_req is high from the next cycle.
- REQ: mem_req, mem_we, mem_be, mem_addr and mem_wdata are held stable until mem_gnt.
  - On mem_gnt, store: mem_req drops next cycle, out_valid pulses, go to IDLE.
  - On mem_gnt, load: go to WAIT_R.
  - mem_rvalid is ignored in REQ.
- WAIT_R: on mem_rvalid, capture and extract the data. out_valid pulses next cycle with the extended value; go to IDLE.
- Byte enables:
  - Byte access: 1<<addr[1:0].
  - Half access: 0011 if addr[1]=0, else 1100.
  - Word access: 1111.
- Write data:
  - SB replicates store_data[7:0] ×4.
  - SH replicates store_data[15:0] ×2.
  - SW passes store_data unchanged.
  - mem_wdata=0 for loads.
- Load extraction: select the byte or half lane by addr[1:0] / addr[1]. LB/LH sign-extend; LBU/LHU zero-extend; LW passes the full word.
- Timeout (TIMEOUT_CYCLES>0):
  - The counter clears on entry to REQ and on entry to WAIT_R, and increments each cycle in those states.
  - When it reaches TIMEOUT_CYCLES: mem_req drops, out_valid=1, bus_fault=1, out_data=0, go to IDLE.
- Stray signals: mem_gnt and mem_rvalid are ignored in IDLE. mem_gnt is ignored in WAIT_R.
- Output registers: out_valid and the fault flags are single-cycle pulses; out_data holds its last value.
- Reset mid-transaction: immediate return to IDLE with mem_req low. The in-flight result is discarded; no out_valid.
- Latency, all from the accept cycle N:
  - Pass-through: out_valid at N+1.
  - Store with gnt at first request cycle: mem_req high in N+1 only, out_valid at N+2.
  - Load with gnt at N+1 and rvalid at N+2: out_valid at N+3.

Decomposition:
- Shared ISA package/header: ALU operation codes, plus an is_load/is_store/access-size classification function and an access-size enum (BYTE, HALF, WORD).
- FSM state enum stays local to this module.
- One natural sub-module, load_data_extractor: combinational lane select plus sign/zero extension, taking op, addr[1:0] and rdata.

Test Plan:
- ADD with alu_result=0x0000_1234 accepted → next cycle out_valid=1, out_data=0x0000_1234, mem_req stays 0.
- SB, addr=0x0000_1003, store_data=0x0000_00AB, gnt on first request cycle → mem_be=1000, mem_addr=0x0000_1000, mem_wdata=0xABAB_ABAB, mem_we=1; out_valid one cycle after gnt.
- LB, addr=0x0000_2002, rdata=0x1280_FF34 → out_data=0xFFFF_FF80. Same access as LBU → 0x0000_0080.
- LW, addr=0x0000_2002 → misaligned_fault=1 with out_valid at N+1, no mem_req. LH, addr=0x0000_2002 → mem_be=1100, no fault.
- TIMEOUT_CYCLES=4, load granted but rvalid never arrives → bus_fault=1 and out_valid 4 cycles after WAIT_R entry, then in_ready=1.
- Store with gnt withheld 3 cycles → mem_req, mem_addr and mem_wdata held stable and in_ready=0 throughout. Assert rst_n=0 in the 2nd cycle → mem_req drops immediately, no out_valid after release.
